// File: rtl/clk_phase_pkg.sv
// Shared constants for the four-phase clock generator:
// FSM state codes, phase numbers and strobe vector bit positions.
package clk_phase_pkg;

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    localparam logic [1:0] PH_PC   = 2'd0;
    localparam logic [1:0] PH_IMEM = 2'd1;
    localparam logic [1:0] PH_DMEM = 2'd2;
    localparam logic [1:0] PH_WB   = 2'd3;

    localparam int STB_W    = 5;
    localparam int STB_PC   = 0;
    localparam int STB_PROC = 1;
    localparam int STB_IMEM = 2;
    localparam int STB_DMEM = 3;
    localparam int STB_WB   = 4;

endpackage

// File: rtl/clock_phase_decode.sv
// Combinational strobe decode: (state, phase) -> 5-bit strobe vector.
// Ports: i_state, i_phase in; o_stb out (bit positions from clk_phase_pkg).
module clock_phase_decode
    import clk_phase_pkg::*;
(
    input  logic [1:0]       i_state,
    input  logic [1:0]       i_phase,
    output logic [STB_W-1:0] o_stb
);

    always_comb begin
        o_stb = '0;
        if (i_state != ST_HALTED) begin
            case (i_phase)
                PH_PC: begin
                    o_stb[STB_PC]   = 1'b1;
                    o_stb[STB_PROC] = 1'b1;
                end
                PH_IMEM: begin
                    o_stb[STB_PC]   = 1'b1;
                    o_stb[STB_PROC] = 1'b1;
                    o_stb[STB_IMEM] = 1'b1;
                end
                PH_DMEM: o_stb[STB_DMEM] = 1'b1;
                default: o_stb[STB_WB]   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/clock_phase_gen.sv
// Four-phase strobe generator with stretched cpu_reset and halt/step control.
// Ports: clock, reset (sync, active-low), halt, step in; phase strobes,
// cpu_reset, phase, halted, cycle_count out (all registered).
module clock_phase_gen
    import clk_phase_pkg::*;
#(
    parameter int RST_HOLD = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
    input  logic             step,
    output logic             PC_clk,
    output logic             processor_clock,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             regfile_clock,
    output logic             cpu_reset,
    output logic [1:0]       phase,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [7:0]       LP_HOLD = 8'(RST_HOLD);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_phase;
    logic [7:0]       r_hold_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [STB_W-1:0] r_stb;
    logic             r_cpu_reset;
    logic             r_halted;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_phase_nxt;
    logic [7:0]       w_hold_nxt;
    logic             w_cnt_inc;
    logic [STB_W-1:0] w_stb_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 2'd1;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_HOLD: begin
                if (r_phase == PH_WB) begin
                    if (r_hold_cnt == LP_HOLD) w_state_nxt = ST_RUN;
                    else w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            ST_RUN: begin
                if (r_phase == PH_WB && halt) begin
                    w_state_nxt = ST_HALTED;
                    w_phase_nxt = PH_WB;
                end
            end
            ST_HALTED: begin
                w_phase_nxt = PH_WB;
                // Releasing halt takes priority over a pending step.
                if (!halt) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = PH_PC;
                end else if (step) begin
                    w_state_nxt = ST_STEP;
                    w_phase_nxt = PH_PC;
                end
            end
            default: begin
                if (r_phase == PH_WB) begin
                    w_state_nxt = ST_HALTED;
                    w_phase_nxt = PH_WB;
                end
            end
        endcase
    end

    // Phase 0 is only ever entered from phase 3, so this fires once per cycle.
    assign w_cnt_inc = (w_phase_nxt == PH_PC) &&
                       (w_state_nxt == ST_RUN || w_state_nxt == ST_STEP);

    clock_phase_decode u_decode (
        .i_state (w_state_nxt),
        .i_phase (w_phase_nxt),
        .o_stb   (w_stb_nxt)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_HOLD;
            r_phase     <= PH_WB;
            r_hold_cnt  <= 8'd0;
            r_cnt       <= '0;
            r_stb       <= '0;
            r_cpu_reset <= 1'b1;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_stb       <= w_stb_nxt;
            r_cpu_reset <= (w_state_nxt == ST_HOLD);
            r_halted    <= (w_state_nxt == ST_HALTED);
            if (w_cnt_inc) r_cnt <= r_cnt + LP_ONE;
        end
    end

    assign PC_clk          = r_stb[STB_PC];
    assign processor_clock = r_stb[STB_PROC];
    assign imem_clock      = r_stb[STB_IMEM];
    assign dmem_clock      = r_stb[STB_DMEM];
    assign regfile_clock   = r_stb[STB_WB];
    assign cpu_reset       = r_cpu_reset;
    assign phase           = r_phase;
    assign halted          = r_halted;
    assign cycle_count     = r_cnt;

endmodule

// File: doc/clock_phase_gen.md
# clock_phase_gen

Upstream timing stage for the single-cycle processor skeleton. It turns the one master `clock` into four-phase registered strobes: `PC_clk`/`processor_clock`, `imem_clock`, `dmem_clock` and `regfile_clock`. It also stretches the board reset into a multi-cycle `cpu_reset`. A halt/single-step control lets the bench or board freeze the core on an instruction boundary.

## Interface
- `RST_HOLD`, default 4: processor cycles for which `cpu_reset` stays high after `reset` releases (1..255).
- `CNT_W`, default 32: width of `cycle_count`.

Ports:
- `clock`  in  1  master clock; every register in the block uses its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low (`reset`=0 resets on the next `clock` rising edge).
- `halt`  in  1  request to freeze at the next instruction boundary; level-sensitive.
- `step`  in  1  while halted, run exactly one processor cycle.
- `PC_clk`  out  1  PC register strobe.
- `processor_clock`  out  1  core strobe; identical to `PC_clk`.
- `imem_clock`  out  1  instruction memory strobe.
- `dmem_clock`  out  1  data memory strobe.
- `regfile_clock`  out  1  register file write strobe.
- `cpu_reset`  out  1  active-high reset to the skeleton.
- `phase`  out  2  current phase, 0..3.
- `halted`  out  1  high when the FSM is in state HALTED.
- `cycle_count`  out  `CNT_W`  number of completed instruction starts.

## Operation
- FSM states: HOLD, RUN, HALTED, STEP. `phase` counts 0→1→2→3→0 in HOLD, RUN and STEP.
- Strobe decode per phase:
  - phase 0: `PC_clk`=`processor_clock`=1.
  - phase 1: `PC_clk`=`processor_clock`=1 and `imem_clock`=1.
  - phase 2: `dmem_clock`=1.
  - phase 3: `regfile_clock`=1.
  - In HALTED, all strobes are 0.
- Strobe ordering: PC updates on the phase-0 rise, instruction fetch on the phase-1 rise, load/store on the phase-2 rise, writeback on the phase-3 rise.
- HOLD:
  - Strobes run normally and `cpu_reset`=1.
  - `hold_cnt` increments on each 3→0 wrap.
  - On the wrap where `hold_cnt`==`RST_HOLD`, go to RUN; `cpu_reset` falls coincident with that phase 0.
  - `halt` and `step` are ignored in HOLD.
- RUN:
  - On the edge leaving phase 3: if `halt`=1, go to HALTED; otherwise go to phase 0.
  - `halt` is sampled only at that edge.
- HALTED: `phase` holds at 3 and all strobes are 0.
  - `halt`=0 → RUN at phase 0.
  - `halt`=1 and `step`=1 → STEP at phase 0.
  - Deasserting `halt` wins over `step`.
- STEP:
  - Runs phases 0..3 once, then returns to HALTED unconditionally.
  - `step` held high produces one processor cycle every 5 clocks.
- `cycle_count` increments on every entry to phase 0 in RUN or STEP, and never in HOLD. It wraps modulo 2^`CNT_W`.

## Timing
- Reset values (the edge with `reset`=0):
  - state=HOLD, `phase`=3, `hold_cnt`=0, `cycle_count`=0.
  - All strobes 0, `cpu_reset`=1, `halted`=0.
- All outputs are registered. They are computed from the next-state/next-phase decode, so `phase` and the strobes change on the same edge with zero relative lag and no glitches.
- First edge after release: `phase`=0 and `PC_clk`=1.
- With `RST_HOLD`=4, `cpu_reset` falls at the 17th edge after release, coincident with phase 0, and `cycle_count` becomes 1 on that same edge.
- Halt latency: at most 4 clocks from `halt` rising to `halted`=1. The exit from HALTED takes 1 clock.
- Reset asserted mid-cycle in any state overrides everything at the next edge. Truncated strobes are acceptable.

## Structure
- Shared package/include `clk_phase_pkg` holds:
  - state encodings HOLD/RUN/HALTED/STEP;
  - phase constants `PH_PC`=0, `PH_IMEM`=1, `PH_DMEM`=2, `PH_WB`=3;
  - the 5-bit strobe vector bit positions.
- One natural sub-module: `clock_phase_decode`. It is combinational, maps (next_state, next_phase) to the strobe vector, and is reused by the bench's reference model.

## Test plan
- Reset low for 3 clocks, then released, `RST_HOLD`=4 → `cpu_reset`=1 for exactly 16 clocks; falls at edge 17 with `phase`=0 and `cycle_count`=1.
- Free run for 40 clocks in RUN → strobe pattern repeats with period 4: `PC_clk` 1,1,0,0; `imem_clock` 0,1,0,0; `dmem_clock` 0,0,1,0; `regfile_clock` 0,0,0,1; `cycle_count` +10.
- `halt`=1 asserted at phase 1 → phases 2 and 3 complete, then `halted`=1 with all strobes 0; `cycle_count` frozen while `halt`=1 for 20 clocks.
- From HALTED, one-clock `step` pulse → exactly one phase 0..3 sequence, then `halted`=1; `cycle_count` +1. `step` held high for 10 clocks → 2 steps.
- In HALTED, `halt`=0 and `step`=1 on the same edge → RUN at phase 0 (not STEP); `halted` falls after 1 clock.
- `reset`=0 at phase 2 in RUN → next edge all strobes 0, `cpu_reset`=1, `cycle_count`=0, state HOLD.
